// File: rtl/fpga_cfg_pkg.sv
// fpga_cfg_pkg: shared config-chain states and connection-block route selects
package fpga_cfg_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, ARMED} cfg_state_e;
  localparam logic [1:0] RSEL_LEFT = 2'd0;
  localparam logic [1:0] RSEL_UP = 2'd1;
  localparam logic [1:0] RSEL_DOWN = 2'd2;
  localparam logic [1:0] RSEL_ZERO = 2'd3;
endpackage

// File: rtl/cfg_chain.sv
// cfg_chain: serial shadow register with armed/commit handshake into an active register
module cfg_chain
  import fpga_cfg_pkg::*;
#(
  parameter int N = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         shift,
  input  logic         din,
  input  logic         commit,
  output logic         dout,
  output logic         armed,
  output logic         valid,
  output logic         err,
  output logic [N-1:0] active
);
  localparam int CW = $clog2(N + 1);
  logic [N-1:0] shadow;
  logic [CW-1:0] count, cnt_inc;
  cfg_state_e state, state_n;
  assign dout = shadow[N-1];
  assign armed = state == ARMED;
  assign cnt_inc = (count == CW'(N)) ? count : count + 1'b1;
  // commit always beats shift; extra shifts while armed just pass bits down the chain
  always_comb begin
    state_n = state;
    if (commit) state_n = (state == ARMED) ? IDLE : state;
    else if (shift && state != ARMED) state_n = (cnt_inc == CW'(N)) ? ARMED : LOAD;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow <= '0;
      active <= '0;
      count <= '0;
      state <= IDLE;
      valid <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= state_n;
      err <= commit && state != ARMED;
      if (commit && state == ARMED) begin
        active <= shadow;
        valid <= 1'b1;
        count <= '0;
      end else if (shift && !commit) begin
        shadow <= {shadow[N-2:0], din};
        count <= cnt_inc;
      end
    end
  end
endmodule

// File: rtl/cblock_chain.sv
// cblock_chain: W-track mux connection block configured through a daisy-chained scan register
module cblock_chain
  import fpga_cfg_pkg::*;
#(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cfg_shift,
  input  logic         cfg_in,
  input  logic         cfg_commit,
  output logic         cfg_out,
  output logic         cfg_armed,
  output logic         cfg_valid,
  output logic         cfg_err,
  input  logic [W-1:0] left_i,
  output logic [W-1:0] right_o,
  input  logic         up_i,
  input  logic         down_i,
  output logic         up_o,
  output logic         down_o
);
  localparam int SELW = $clog2(W + 2);
  localparam int CFG_BITS = 2 * W + 2 * SELW;
  localparam int LX = 1 << SELW;
  logic [CFG_BITS-1:0] active;
  logic [SELW-1:0] up_sel, down_sel;
  logic [LX-1:0] left_x;
  cfg_chain #(.N(CFG_BITS)) u_chain (
    .clk(clk),
    .rst_n(rst_n),
    .shift(cfg_shift),
    .din(cfg_in),
    .commit(cfg_commit),
    .dout(cfg_out),
    .armed(cfg_armed),
    .valid(cfg_valid),
    .err(cfg_err),
    .active(active)
  );
  for (genvar i = 0; i < W; i++) begin : g_r
    logic [1:0] rs;
    assign rs = active[2*i +: 2];
    assign right_o[i] = cfg_valid & (rs == RSEL_LEFT ? left_i[i] : rs == RSEL_UP ? up_i :
                                     rs == RSEL_DOWN ? down_i : 1'b0);
  end
  // zero-padded track vector makes every select above W read 0
  assign left_x = LX'(left_i);
  assign up_sel = active[2*W +: SELW];
  assign down_sel = active[2*W+SELW +: SELW];
  assign up_o = cfg_valid & (up_sel == SELW'(W) ? down_i : left_x[up_sel]);
  assign down_o = cfg_valid & (down_sel == SELW'(W) ? up_i : left_x[down_sel]);
endmodule

// File: tb/tb_cblock_chain.sv
// tb_cblock_chain: randomized scoreboard bench for the connection block against a behavioural model
module tb_cblock_chain;
  localparam int W = 3;
  localparam int N = 12;
  logic clk = 0, rst_n = 0, cfg_shift = 0, cfg_in = 0, cfg_commit = 0;
  logic cfg_out, cfg_armed, cfg_valid, cfg_err, up_o, down_o;
  logic up_i = 0, down_i = 0;
  logic [W-1:0] left_i = '0, right_o;
  logic [8:0] q[$];
  logic [8:0] exp_v, got_v;
  int checks = 0, errors = 0;
  logic [N-1:0] m_sh = '0, m_act = '0;
  int m_cnt = 0;
  logic m_vld = 0, m_err = 0;
  logic p_rst = 0, p_s = 0, p_i = 0, p_c = 0;

  always #5 clk = ~clk;

  cblock_chain #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_shift(cfg_shift), .cfg_in(cfg_in), .cfg_commit(cfg_commit),
    .cfg_out(cfg_out), .cfg_armed(cfg_armed), .cfg_valid(cfg_valid), .cfg_err(cfg_err),
    .left_i(left_i), .right_o(right_o), .up_i(up_i), .down_i(down_i), .up_o(up_o), .down_o(down_o)
  );

  function automatic logic [4:0] route(input logic [N-1:0] act, input logic vld,
                                       input logic [W-1:0] l, input logic u, input logic d);
    logic [W-1:0] r;
    int f, us, ds;
    logic uo, dn;
    if (!vld) return 5'b0;
    for (int i = 0; i < W; i++) begin
      f = int'((act >> (2 * i)) & 12'd3);
      r[i] = f == 0 ? l[i] : f == 1 ? u : f == 2 ? d : 1'b0;
    end
    us = int'((act >> 6) & 12'd7);
    ds = int'((act >> 9) & 12'd7);
    uo = us < W ? l[us] : us == W ? d : 1'b0;
    dn = ds < W ? l[ds] : ds == W ? u : 1'b0;
    return {r, uo, dn};
  endfunction

  task automatic cycr(input logic r, input logic s, input logic i, input logic c,
                      input logic [W-1:0] l, input logic u, input logic d);
    @(posedge clk);
    if (!p_rst) begin
      m_sh = '0; m_act = '0; m_cnt = 0; m_vld = 0; m_err = 0;
    end else if (p_c) begin
      m_err = m_cnt != N;
      if (m_cnt == N) begin
        m_act = m_sh; m_vld = 1; m_cnt = 0;
      end
    end else begin
      m_err = 0;
      if (p_s) begin
        m_sh = {m_sh[N-2:0], p_i};
        if (m_cnt < N) m_cnt++;
      end
    end
    #1;
    p_rst = r; p_s = s; p_i = i; p_c = c;
    rst_n = r; cfg_shift = s; cfg_in = i; cfg_commit = c;
    left_i = l; up_i = u; down_i = d;
    q.push_back({m_sh[N-1], m_cnt == N, m_vld, m_err, route(m_act, m_vld, l, u, d)});
  endtask

  task automatic cyc(input logic r, input logic s, input logic i, input logic c);
    cycr(r, s, i, c, 3'($urandom()), 1'($urandom()), 1'($urandom()));
  endtask

  task automatic load(input logic [N-1:0] bits, input int nb);
    for (int k = nb - 1; k >= 0; k--) cyc(1, 1, bits[k], 0);
  endtask

  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_v = q.pop_front();
      got_v = {cfg_out, cfg_armed, cfg_valid, cfg_err, right_o, up_o, down_o};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL outputs t=%0t got=%b expected=%b (out,armed,valid,err,right,up,down)",
                 $time, got_v, exp_v);
      end
    end
  end

  initial begin
    repeat (3) cyc(0, 0, 0, 0);
    repeat (4) cyc(1, 0, 0, 0);
    @(negedge clk); #1;
    checks++;
    if ({cfg_out, cfg_armed, cfg_valid, cfg_err, right_o, up_o, down_o} !== 9'b0) begin
      errors++;
      $display("FAIL reset_idle got=%b expected=0",
               {cfg_out, cfg_armed, cfg_valid, cfg_err, right_o, up_o, down_o});
    end
    load(12'b011_100_10_01_00, N);
    cyc(1, 0, 0, 1);
    cycr(1, 0, 0, 0, 3'b101, 1'b1, 1'b0);
    @(negedge clk); #1;
    checks++;
    if ({right_o, up_o, down_o} !== 5'b011_0_1) begin
      errors++;
      $display("FAIL known_route got=%b expected=01101", {right_o, up_o, down_o});
    end
    load(12'($urandom()), 7);
    cyc(1, 0, 0, 1);
    cyc(1, 0, 0, 0);
    load(12'($urandom()), 5);
    cyc(1, 0, 0, 1);
    repeat (3) cyc(1, 0, 0, 0);
    load(12'($urandom()), N);
    load(12'($urandom()), N);
    cyc(1, 0, 0, 1);
    cyc(1, 0, 0, 0);
    load(12'($urandom()), N);
    load(12'($urandom()), 3);
    cyc(1, 1, 1, 1);
    repeat (2) cyc(1, 0, 0, 0);
    load(12'($urandom()), 5);
    cyc(0, 0, 0, 0);
    repeat (3) cyc(1, 0, 0, 0);
    for (int k = 0; k < 6; k++) begin
      load(12'($urandom()), N);
      cyc(1, 0, 0, 1);
      repeat (2) cyc(1, 0, 0, 0);
    end
    for (int k = 0; k < 800; k++)
      cyc($urandom_range(63, 0) != 0, 1'($urandom()), 1'($urandom()), $urandom_range(15, 0) == 0);
    cyc(1, 0, 0, 0);
    repeat (4) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d expected=0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
